// File: rtl/game_tick_gen.sv
// ============================================================================
// game_tick_gen : multi-channel programmable tick / divided-clock generator
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module game_tick_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 125000000,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              div_we,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  input  logic [NUM_CH-1:0] mode,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_div
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  logic w_wr_ok;
  assign w_wr_ok = div_we && (int'(div_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_tick;
    logic             r_clk_div;
    logic [CNT_W-1:0] w_last;
    logic             w_sel;
    logic             w_tick_n;
    logic             w_level_n;
    logic [CNT_W-1:0] w_cnt_n;

    // A zero divisor behaves as one: terminal count is then 0.
    assign w_last = (r_div == '0) ? '0 : r_div - CNT_W'(1);
    assign w_sel  = w_wr_ok && (div_ch == CH_W'(i));

    always_comb begin
      w_tick_n  = 1'b0;
      w_level_n = r_level;
      w_cnt_n   = r_cnt;
      if (w_sel) begin
        w_cnt_n = '0;
      end else if (en) begin
        if (r_cnt == w_last) begin
          w_cnt_n   = '0;
          w_tick_n  = 1'b1;
          w_level_n = ~r_level;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_div     <= RST_DIV;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_tick    <= 1'b0;
        r_clk_div <= 1'b0;
      end else if (sync_clr) begin
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_tick    <= 1'b0;
        r_clk_div <= 1'b0;
      end else begin
        if (w_sel) begin
          r_div <= div_val;
        end
        r_cnt     <= w_cnt_n;
        r_level   <= w_level_n;
        r_tick    <= w_tick_n;
        r_clk_div <= mode[i] ? w_tick_n : w_level_n;
      end
    end

    assign tick[i]    = r_tick;
    assign clk_div[i] = r_clk_div;
  end

endmodule

`default_nettype wire

// File: tb/tb_game_tick_gen.sv
// Randomized scoreboard bench for game_tick_gen (NUM_CH=2, CNT_W=8, DEFAULT_DIV=4).
`default_nettype none

module tb_game_tick_gen;

  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int DEF = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          sync_clr = 1'b0;
  logic          div_we = 1'b0;
  logic [1:0]    div_ch = '0;
  logic [CW-1:0] div_val = '0;
  logic [NCH-1:0] mode = '0;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clk_div;

  game_tick_gen #(
    .NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DEF), .CH_W(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .div_we(div_we),
    .div_ch(div_ch), .div_val(div_val), .mode(mode), .tick(tick), .clk_div(clk_div)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_div;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: divisor, position within period, output level per channel
  int m_div[NCH];
  int m_pos[NCH];
  int m_lvl[NCH];

  task automatic chk(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, got, want);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic c, input logic w,
                      input logic [1:0] ch, input logic [CW-1:0] v, input logic [NCH-1:0] m);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; sync_clr = c; div_we = w; div_ch = ch; div_val = v; mode = m;
    x = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r) begin
        m_div[i] = DEF; m_pos[i] = 0; m_lvl[i] = 0;
      end else if (c) begin
        m_pos[i] = 0; m_lvl[i] = 0;
      end else if (w && int'(ch) == i) begin
        m_div[i] = int'(v); m_pos[i] = 0;
      end else if (e) begin
        m_pos[i] = m_pos[i] + 1;
        if (m_pos[i] >= ((m_div[i] == 0) ? 1 : m_div[i])) begin
          m_pos[i] = 0;
          m_lvl[i] = 1 - m_lvl[i];
          x.tick[i] = 1'b1;
        end
      end
      if (!r && !c) x.clk_div[i] = m[i] ? x.tick[i] : m_lvl[i][0];
    end
    exp_q.push_back(x);
  endtask

  // Monitor: compare every registered output sample against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tick", tick, e.tick);
        chk("clk_div", clk_div, e.clk_div);
      end
    end
  end

  initial begin
    logic r, e, c, w;
    logic [1:0] ch;
    logic [CW-1:0] v;
    logic [NCH-1:0] m;

    step(1, 0, 0, 0, 0, 0, 2'b00);
    step(1, 0, 0, 0, 0, 0, 2'b00);
    @(posedge clk); #1;
    chk("reset_tick", tick, 2'b00);
    chk("reset_clk_div", clk_div, 2'b00);

    // Default divisor 4: ticks on edges 4 and 8, clk_div[0] rises at 4, falls at 8
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, 0, 0, 0, 0, 2'b00);
      @(posedge clk); #1;
      chk("dflt_tick0", {1'b0, tick[0]}, {1'b0, (k == 4 || k == 8)});
      if (k == 4) chk("dflt_rise", {1'b0, clk_div[0]}, 2'b01);
      if (k == 8) chk("dflt_fall", {1'b0, clk_div[0]}, 2'b00);
    end

    // Divisor 0 on ch1 in pulse mode: high every cycle from the second edge
    step(0, 1, 0, 1, 1, 0, 2'b10);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 0, 0, 2'b10);
      @(posedge clk); #1;
      chk("div0_tick1", {1'b0, tick[1]}, 2'b01);
      chk("div0_clk1", {1'b0, clk_div[1]}, 2'b01);
    end

    // Out-of-range write, then clear with concurrent write
    step(0, 1, 0, 1, 3, 1, 2'b00);
    step(0, 1, 1, 1, 0, 9, 2'b00);
    @(posedge clk); #1;
    chk("clr_outputs", tick | clk_div, 2'b00);
    for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 0, 0, 2'b00);

    m = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 99) == 0);
      w  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 99) < 85);
      ch = 2'($urandom_range(0, 3));
      v  = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 19) == 0) m = 2'($urandom_range(0, 3));
      step(r, e, c, w, ch, v, m);
    end

    @(posedge clk); #2;
    if (exp_q.size() != 0) chk("queue_drain", 2'(exp_q.size()), 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/game_tick_gen.md
GAME_TICK_GEN -- requirements
Module: game_tick_gen

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 32, SHALL set the width of each channel counter and divisor register.
REQ-003 Parameter DEFAULT_DIV, default 125000000, SHALL set the divisor loaded into every channel at reset.
REQ-004 Parameter CH_W, default $clog2(NUM_CH) with a minimum of 1, SHALL set the width of the channel select.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-007 en  in  1  SHALL be the global count enable.
REQ-008 sync_clr  in  1  SHALL be a synchronous phase-align clear of all channels.
REQ-009 div_we  in  1  SHALL be the divisor write strobe.
REQ-010 div_ch  in  CH_W  SHALL select the channel written.
REQ-011 div_val  in  CNT_W  SHALL be the divisor value written.
REQ-012 mode  in  NUM_CH  SHALL select the output mode per channel: 0 = toggle, 1 = pulse.
REQ-013 tick  out  NUM_CH  SHALL carry a one-cycle pulse per channel at each terminal count.
REQ-014 clk_div  out  NUM_CH  SHALL carry the registered per-channel divided output.

Function
REQ-015 Each channel SHALL hold a divisor D[i] and a counter cnt[i], both CNT_W wide.
- Effective divisor E = max(D[i], 1), so D = 0 behaves as D = 1.
REQ-016 When en = 1 and no higher-priority event applies:
- if cnt[i] == E-1: cnt[i] <= 0, tick[i] <= 1, and level[i] toggles;
- otherwise: cnt[i] <= cnt[i]+1 and tick[i] <= 0.
REQ-017 When en = 0, all counters and levels SHALL hold, and tick SHALL be 0 on the next cycle.
REQ-018 clk_div[i] SHALL be a registered output:
- level[i] when mode[i] = 0 (period 2E cycles, 50% duty);
- the same value as tick[i] when mode[i] = 1 (high 1 cycle in every E).
REQ-019 A change of mode[i] SHALL affect clk_div[i] from the next clock edge; it SHALL NOT disturb the counter or the level.
REQ-020 When div_we = 1 and div_ch < NUM_CH, the selected channel SHALL on the same edge:
- set D <= div_val;
- set cnt <= 0;
- set tick <= 0;
- keep its level.
REQ-021 A write with div_ch >= NUM_CH SHALL be ignored.
REQ-022 Priority per edge SHALL be: rst > sync_clr > div_we > en-count.
- A write to a channel that is at its terminal count SHALL suppress that channel's tick and toggle.
- Unwritten channels SHALL count normally in the same cycle.
REQ-023 sync_clr = 1 SHALL clear all cnt, level, tick and clk_div to 0, keep all divisors, and ignore a simultaneous div_we.
REQ-024 The counter SHALL never exceed E-1.
- If a write lowers D while cnt >= new E-1, the write's counter reset (REQ-020) covers this case.
REQ-025 The counter SHALL wrap only through the terminal-count path; no other overflow SHALL occur.
REQ-026 Latency from the edge on which cnt reaches E-1 to tick/clk_div updating SHALL be one edge, because outputs are registered.

Reset
REQ-027 With rst = 1 at a clock edge, the block SHALL set:
- every D <= DEFAULT_DIV;
- every cnt <= 0;
- every level <= 0;
- tick <= 0 and clk_div <= 0.
REQ-028 rst asserted mid-period SHALL abort the period with no tick emitted; counting SHALL restart from 0 on the first edge after rst deasserts with en = 1.

Verification (NUM_CH=2, CNT_W=8, DEFAULT_DIV=4)
REQ-029 Reset, then en=1, mode=00 -> tick[0] is high on edges 4, 8, 12 after reset release; clk_div[0] toggles 0->1 at edge 4 and 1->0 at edge 8.
REQ-030 div_we=1, div_ch=1, div_val=0, mode[1]=1 -> tick[1] and clk_div[1] are high every cycle from the second edge after the write.
REQ-031 en dropped for 10 cycles at cnt=2 -> no ticks during the gap; the next tick comes 2 enabled cycles after en returns.
REQ-032 div_we on ch0 in the same cycle cnt[0]=3 (terminal) -> no tick[0] that cycle, level unchanged, then a tick after div_val cycles; ch1 unaffected.
REQ-033 sync_clr together with div_we (div_ch=0, div_val=9) -> all outputs 0, D[0] stays 4, and the next tick[0] comes 4 cycles later.
REQ-034 Write with div_ch=3 (>= NUM_CH) -> no state change in any channel.
